// File: rtl/vga_sync_receiver.sv
// Recovers VGA timing from hsync/vsync, checks line and frame lengths, and re-emits
// active-area pixels with their coordinates one clock after they are sampled.
module vga_sync_receiver #(
   parameter int H_TOTAL     = 800,
   parameter int H_ACT_START = 144,
   parameter int H_ACT       = 640,
   parameter int V_TOTAL     = 525,
   parameter int V_ACT_START = 35,
   parameter int V_ACT       = 480
) (
   input  logic        vga_clk,
   input  logic        rstn,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_err,
   output logic [7:0]  err_cnt
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_END  = 10'(H_TOTAL);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_LO   = 10'(H_ACT_START);
   localparam logic [9:0] H_HI   = 10'(H_ACT_START + H_ACT);
   localparam logic [9:0] V_LO   = 10'(V_ACT_START);
   localparam logic [9:0] V_HI   = 10'(V_ACT_START + V_ACT);
   localparam logic [9:0] POS_MAX = 10'h3FF;

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t     state, state_next;
   logic       hs_d, vs_d, hs_rise, vs_rise, line_seen;
   logic [9:0] h_pos, v_pos, h_cur, v_cur;
   logic       line_bad, frame_bad, line_overrun, lock_fail, active;

   // h_cur/v_cur are the coordinates of the sample currently on the inputs;
   // h_pos/v_pos hold those of the previous sample, so they measure the line/frame just ended.
   always_comb begin
      hs_rise = hsync & ~hs_d;
      vs_rise = vsync & ~vs_d;
      if (hs_rise)
         h_cur = '0;
      else if (h_pos == POS_MAX)
         h_cur = h_pos;
      else
         h_cur = h_pos + 10'd1;
      if (vs_rise)
         v_cur = '0;
      else if (hs_rise && (v_pos != POS_MAX))
         v_cur = v_pos + 10'd1;
      else
         v_cur = v_pos;
      line_bad     = hs_rise && (h_pos != H_LAST);
      frame_bad    = vs_rise && (v_pos != V_LAST);
      line_overrun = !hs_rise && (h_cur == H_END);
   end

   always_comb begin
      state_next = state;
      lock_fail  = 1'b0;
      case (state)
         SEARCH: begin
            if (vs_rise)
               state_next = CHECK;
         end
         CHECK: begin
            // A line that started before any observed hsync edge has no meaningful length.
            if ((line_bad && line_seen) || frame_bad)
               state_next = SEARCH;
            else if (vs_rise)
               state_next = LOCKED;
         end
         LOCKED: begin
            lock_fail = line_bad || frame_bad || line_overrun;
            if (lock_fail)
               state_next = SEARCH;
         end
         default: state_next = SEARCH;
      endcase
      active = (state == LOCKED) && !lock_fail &&
               (h_cur >= H_LO) && (h_cur < H_HI) &&
               (v_cur >= V_LO) && (v_cur < V_HI);
   end

   always_ff @(posedge vga_clk) begin
      if (!rstn)
         state <= SEARCH;
      else
         state <= state_next;
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge vga_clk) begin
      if (!rstn) begin
         hs_d        <= 1'b0;
         vs_d        <= 1'b0;
         line_seen   <= 1'b0;
         h_pos       <= '0;
         v_pos       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         timing_err  <= 1'b0;
         err_cnt     <= '0;
      end else begin
         hs_d        <= hsync;
         vs_d        <= vsync;
         h_pos       <= h_cur;
         v_pos       <= v_cur;
         if (hs_rise)
            line_seen <= 1'b1;
         pix_valid   <= active;
         pix_rgb     <= active ? rgb : 12'h000;
         frame_start <= active && (h_cur == H_LO) && (v_cur == V_LO);
         if (active) begin
            pix_x <= h_cur - H_LO;
            pix_y <= v_cur - V_LO;
         end
         timing_err  <= lock_fail;
         if (lock_fail && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster: event-based timing model plus
// scenario checks for locking, line/frame errors, stuck hsync, saturation and reset.
module tb_vga_sync_receiver;

   localparam int HT  = 12;
   localparam int HAS = 3;
   localparam int HA  = 6;
   localparam int VT  = 5;
   localparam int VAS = 1;
   localparam int VA  = 3;

   logic        vga_clk = 1'b0;
   logic        rstn, hsync, vsync;
   logic [11:0] rgb;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pix_rgb;
   logic        pix_valid, frame_start, locked, timing_err;
   logic [7:0]  err_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   vga_sync_receiver #(
      .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA),
      .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA)
   ) dut (
      .vga_clk(vga_clk), .rstn(rstn), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
      .err_cnt(err_cnt)
   );

   always #5 vga_clk = ~vga_clk;

   // Reference model: positions come from cycle stamps of the last sync edges,
   // and lock follows the frame-level acceptance rules.
   int n = 0, last_hs = 0, lines = 0, mode = 0;
   bit started = 0, seen = 0, hs_prev = 0, vs_prev = 0;
   int exp_x = 0, exp_y = 0, exp_rgb = 0, exp_cnt = 0;
   bit exp_valid = 0, exp_fs = 0, exp_locked = 0, exp_err = 0;

   always @(posedge vga_clk) begin
      int  len, h_now, v_now;
      bit  hr, vr, bad_line, bad_frame, overrun, fail, act;
      n++;
      if (!rstn) begin
         started = 1; mode = 0; seen = 0; hs_prev = 0; vs_prev = 0;
         last_hs = n; lines = 0;
         exp_x = 0; exp_y = 0; exp_rgb = 0; exp_cnt = 0;
         exp_valid = 0; exp_fs = 0; exp_locked = 0; exp_err = 0;
      end else begin
         hr = hsync && !hs_prev;
         vr = vsync && !vs_prev;
         len = n - last_hs;
         h_now = hr ? 0 : (len > 1023 ? 1023 : len);
         v_now = vr ? 0 : (hr ? (lines >= 1023 ? 1023 : lines + 1) : lines);
         bad_line  = hr && (len != HT);
         bad_frame = vr && (lines != VT - 1);
         overrun   = !hr && (h_now == HT);
         fail = (mode == 2) && (bad_line || bad_frame || overrun);
         act = (mode == 2) && !fail && h_now >= HAS && h_now < HAS + HA &&
               v_now >= VAS && v_now < VAS + VA;
         exp_valid = act;
         exp_rgb   = act ? int'(rgb) : 0;
         exp_fs    = act && h_now == HAS && v_now == VAS;
         if (act) begin
            exp_x = h_now - HAS;
            exp_y = v_now - VAS;
         end
         exp_err = fail;
         if (fail && exp_cnt < 255) exp_cnt++;
         if (mode == 0) begin
            if (vr) mode = 1;
         end else if (mode == 1) begin
            if ((bad_line && seen) || bad_frame) mode = 0;
            else if (vr) mode = 2;
         end else if (fail) begin
            mode = 0;
         end
         exp_locked = (mode == 2);
         if (hr) begin last_hs = n; seen = 1; end
         lines = v_now;
         hs_prev = hsync;
         vs_prev = vsync;
      end
   end

   task automatic cmp(input string name, input int act, input int expv);
      tests_run++;
      if (act != expv) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic checkOutput();
      cmp("pix_valid", int'(pix_valid), int'(exp_valid));
      cmp("pix_rgb", int'(pix_rgb), exp_rgb);
      cmp("pix_x", int'(pix_x), exp_x);
      cmp("pix_y", int'(pix_y), exp_y);
      cmp("frame_start", int'(frame_start), int'(exp_fs));
      cmp("locked", int'(locked), int'(exp_locked));
      cmp("timing_err", int'(timing_err), int'(exp_err));
      cmp("err_cnt", int'(err_cnt), exp_cnt);
   endtask

   always @(negedge vga_clk) begin
      if (started) checkOutput();
   end

   // Scenario scoreboard counters, sampled right after each driven cycle
   int cnt_valid = 0, cnt_fs = 0, cnt_err = 0;
   int last_rgb = -1;

   task automatic clearCounts();
      cnt_valid = 0; cnt_fs = 0; cnt_err = 0; last_rgb = -1;
   endtask

   task automatic applyStimulus(input bit hs, input bit vs, input logic [11:0] c);
      hsync = hs;
      vsync = vs;
      rgb   = c;
      @(negedge vga_clk);
      cnt_valid += int'(pix_valid);
      cnt_fs    += int'(frame_start);
      cnt_err   += int'(timing_err);
      if (pix_valid && pix_x == 10'(HA - 1) && pix_y == 10'(VA - 1))
         last_rgb = int'(pix_rgb);
   endtask

   task automatic sendLine(input int len, input int vs_cycles, input int hw,
                           input bit pattern, input int l);
      logic [11:0] c;
      for (int k = 0; k < len; k++) begin
         if (pattern && l >= VAS && l < VAS + VA && k >= HAS && k < HAS + HA)
            c = 12'((l - VAS) * HA + (k - HAS));
         else
            c = 12'($urandom);
         applyStimulus(k < hw, k < vs_cycles, c);
      end
   endtask

   task automatic sendFrame(input int nlines, input int short_idx, input bit pattern);
      for (int l = 0; l < nlines; l++) begin
         int len;
         len = (l == short_idx) ? HT - 1 : HT;
         sendLine(len, (l == 0) ? len : 0, 2, pattern, l);
      end
   endtask

   task automatic resetPulse(input int cycles);
      rstn = 1'b0;
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 12'($urandom));
      rstn = 1'b1;
   endtask

   initial begin
      repeat (200000) @(posedge vga_clk);
      tests_failed++;
      $display("[TB] FAIL watchdog: cycle budget of %0d expired", 200000);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstn = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
      @(negedge vga_clk);

      resetPulse(3);
      cmp("reset_locked", int'(locked), 0);
      cmp("reset_valid", int'(pix_valid), 0);
      cmp("reset_err_cnt", int'(err_cnt), 0);

      // Nominal raster: first frame only arms CHECK, second vsync edge locks
      clearCounts();
      sendFrame(VT, -1, 1'b1);
      cmp("nominal_f1_locked", int'(locked), 0);
      cmp("nominal_f1_valid", cnt_valid, 0);
      clearCounts();
      sendFrame(VT, -1, 1'b1);
      cmp("nominal_f2_locked", int'(locked), 1);
      cmp("nominal_f2_valid", cnt_valid, HA * VA);
      cmp("nominal_f2_fs", cnt_fs, 1);
      cmp("nominal_last_rgb", last_rgb, HA * VA - 1);
      clearCounts();
      sendFrame(VT, -1, 1'b1);
      cmp("nominal_f3_valid", cnt_valid, HA * VA);
      cmp("aligned_sync_no_err", cnt_err, 0);

      // One short line while locked
      clearCounts();
      sendFrame(VT, 2, 1'b0);
      cmp("short_line_err_pulses", cnt_err, 1);
      cmp("short_line_err_cnt", int'(err_cnt), 1);
      cmp("short_line_locked", int'(locked), 0);
      sendFrame(VT, -1, 1'b0);
      cmp("relock_after_one", int'(locked), 0);
      sendFrame(VT, -1, 1'b0);
      cmp("relock_after_two", int'(locked), 1);

      // Frame one line short while locked: caught at the following vsync edge
      sendFrame(VT - 1, -1, 1'b0);
      cmp("short_frame_still_locked", int'(locked), 1);
      clearCounts();
      sendFrame(VT, -1, 1'b0);
      cmp("short_frame_err_pulses", cnt_err, 1);
      cmp("short_frame_err_cnt", int'(err_cnt), 2);
      cmp("short_frame_locked", int'(locked), 0);
      sendFrame(VT, -1, 1'b0);
      sendFrame(VT, -1, 1'b0);
      cmp("relock_after_short_frame", int'(locked), 1);

      // hsync stuck low while locked, then repeated until err_cnt saturates
      clearCounts();
      sendLine(HT + 4, 0, 0, 1'b0, 0);
      cmp("stuck_err_pulses", cnt_err, 1);
      cmp("stuck_err_cnt", int'(err_cnt), 3);
      cmp("stuck_locked", int'(locked), 0);
      clearCounts();
      for (int i = 0; i < 300; i++) begin
         sendFrame(VT, -1, 1'b0);
         sendLine(HT + 4, 2, 2, 1'b0, 0);
      end
      cmp("saturation_pulses", cnt_err, 300);
      cmp("saturation_err_cnt", int'(err_cnt), 255);

      // Reset in the middle of the active area of a locked frame
      sendFrame(VT, -1, 1'b0);
      sendFrame(VT, -1, 1'b0);
      cmp("pre_reset_locked", int'(locked), 1);
      sendLine(HT, HT, 2, 1'b0, 0);
      sendLine(HT, 0, 2, 1'b0, 1);
      sendLine(HAS + HA / 2, 0, 2, 1'b0, 2);
      cmp("pre_reset_valid", int'(pix_valid), 1);
      resetPulse(1);
      cmp("mid_reset_valid", int'(pix_valid), 0);
      cmp("mid_reset_rgb", int'(pix_rgb), 0);
      cmp("mid_reset_x", int'(pix_x), 0);
      cmp("mid_reset_locked", int'(locked), 0);
      cmp("mid_reset_err_cnt", int'(err_cnt), 0);
      clearCounts();
      sendFrame(VT, -1, 1'b1);
      cmp("post_reset_check_valid", cnt_valid, 0);
      cmp("post_reset_check_locked", int'(locked), 0);
      clearCounts();
      sendFrame(VT, -1, 1'b1);
      cmp("post_reset_relock_valid", cnt_valid, HA * VA);
      cmp("post_reset_relocked", int'(locked), 1);

      // Randomized rasters with occasional line/frame length and sync width errors
      for (int f = 0; f < 40; f++) begin
         int nl;
         nl = VT;
         if ($urandom_range(0, 7) == 0) nl = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
         for (int l = 0; l < nl; l++) begin
            int len;
            len = HT;
            if ($urandom_range(0, 39) == 0) len = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 1;
            sendLine(len, (l == 0) ? len : 0, $urandom_range(1, 3), 1'b0, l);
         end
      end
      sendFrame(VT, -1, 1'b0);
      sendFrame(VT, -1, 1'b0);
      cmp("final_locked", int'(locked), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pixel clocks per line.
REQ-002 SHALL have parameter H_ACT_START, default 144, meaning first active pixel offset after hsync rise.
REQ-003 SHALL have parameter H_ACT, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-005 SHALL have parameter V_ACT_START, default 35, meaning first active line offset after vsync rise.
REQ-006 SHALL have parameter V_ACT, default 480, meaning active lines per frame.
REQ-007 SHALL have ports: vga_clk  in  1  pixel clock, sole clock; rstn  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: hsync  in  1  active-high line sync; vsync  in  1  active-high frame sync; rgb  in  12  pixel colour.
REQ-009 SHALL have ports: pix_x  out  10  active-area X; pix_y  out  10  active-area Y; pix_rgb  out  12  captured colour; pix_valid  out  1  pixel strobe.
REQ-010 SHALL have ports: frame_start  out  1  one-cycle pulse at pixel (0,0); locked  out  1  timing lock; timing_err  out  1  one-cycle error pulse; err_cnt  out  8  saturating error count.

Function
REQ-011 SHALL register hsync/vsync once (hs_d, vs_d); rising edge = input high while delayed copy low.
REQ-012 SHALL keep h_pos (10 b): 0 on the sample showing hsync rise, +1 per clock thereafter, no wrap (saturate at 1023).
REQ-013 SHALL keep v_pos (10 b): 0 on the line where vsync rise is seen, +1 on each hsync rise, saturate at 1023.
REQ-014 SHALL run FSM SEARCH -> CHECK -> LOCKED; reset state SEARCH.
REQ-015 SEARCH: on vsync rise go CHECK; locked=0, pix_valid=0.
REQ-016 CHECK: every hsync rise SHALL find previous line length exactly H_TOTAL (not checked on first line); next vsync rise SHALL find v_pos==V_TOTAL-1; pass -> LOCKED, mismatch -> SEARCH.
REQ-017 LOCKED: locked=1; hsync rise with line length != H_TOTAL, or vsync rise with v_pos != V_TOTAL-1, or h_pos reaching H_TOTAL without hsync rise SHALL raise timing_err and return to SEARCH.
REQ-018 Failure from CHECK SHALL NOT pulse timing_err; only LOCKED failures count.
REQ-019 Sample is active when state LOCKED, H_ACT_START<=h_pos<H_ACT_START+H_ACT, V_ACT_START<=v_pos<V_ACT_START+V_ACT.
REQ-020 Latency 1 clock: for an active sample, next cycle pix_valid=1, pix_x=h_pos-H_ACT_START, pix_y=v_pos-V_ACT_START, pix_rgb=rgb of that sample.
REQ-021 Non-active sample: pix_valid=0, pix_rgb=0, pix_x/pix_y hold last values.
REQ-022 frame_start SHALL assert with the pix_valid of pixel (0,0) only.
REQ-023 err_cnt SHALL increment per timing_err, saturate at 255.
REQ-024 Simultaneous hsync and vsync rise: both counters reset same cycle (h_pos=0, v_pos=0); both checks applied.
REQ-025 Leaving LOCKED SHALL deassert locked and pix_valid the next cycle; a pixel in flight is dropped.

Reset
REQ-026 rstn=0 at a vga_clk edge SHALL force state SEARCH, h_pos=v_pos=0, hs_d=vs_d=0, all outputs 0, err_cnt=0.
REQ-027 Reset mid-frame SHALL discard lock; relock requires full CHECK frame after release.

Verification
REQ-028 Nominal 640x480 timing, rgb=pixel index: locked after 2nd vsync rise; 307200 pix_valid/frame; pixel (639,479) rgb matches; one frame_start per frame.
REQ-029 Locked, one line shortened to 799 clocks: timing_err 1 cycle at next hsync rise, err_cnt=1, locked=0; relock after 2 good frames.
REQ-030 Locked, frame of 524 lines: timing_err at vsync rise, state SEARCH.
REQ-031 hsync stuck low while locked: timing_err when h_pos hits 800; err_cnt saturates at 255 after 300 forced errors.
REQ-032 rstn pulsed low at pixel (320,240): all outputs 0 next cycle; no pix_valid until CHECK frame completes.
REQ-033 hsync/vsync rising same cycle at frame boundary: h_pos=v_pos=0, no false timing_err.
